// File: rtl/nibble_add_seq.sv
// ============================================================================
// nibble_add_seq : drives one external 4-bit adder a nibble per cycle to
//                  build a NIBBLES*4-bit add/subtract with carry chaining.
// Revision 1.0
// ============================================================================
`default_nettype none

module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 op_cin,
  input  logic                 op_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] res_sum,
  output logic                 res_cout,
  output logic                 res_ovf,
  output logic [3:0]           fa_a,
  output logic [3:0]           fa_b,
  output logic                 fa_cin,
  input  logic [3:0]           fa_sum,
  input  logic                 fa_cout
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDXW-1:0] c_LAST = IDXW'(NIBBLES - 1);

  logic [1:0]      r_state;
  logic [IDXW-1:0] r_idx;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;

  logic            w_run;
  logic [IDXW+1:0] w_base;

  assign w_run  = (r_state == S_RUN);
  assign w_base = {r_idx, 2'b00};

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign res_sum   = r_sum;
  assign res_cout  = r_cout;
  assign res_ovf   = r_ovf;

  // Adder pins are parked at zero whenever no nibble is in flight.
  assign fa_a   = w_run ? r_a[w_base +: 4] : 4'd0;
  assign fa_b   = w_run ? r_b[w_base +: 4] : 4'd0;
  assign fa_cin = w_run ? r_carry : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            // Subtract is A + ~B + 1, so B is stored pre-inverted.
            r_b     <= op_sub ? ~op_b : op_b;
            r_carry <= op_sub ? 1'b1 : op_cin;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[w_base +: 4] <= fa_sum;
          r_carry            <= fa_cout;
          if (r_idx == c_LAST) begin
            r_cout  <= fa_cout;
            r_ovf   <= (r_a[W-1] == r_b[W-1]) && (fa_sum[3] != r_a[W-1]);
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nibble_add_seq.sv
// ============================================================================
// tb_nibble_add_seq : directed bench with a behavioural 4-bit adder and a
//                     result scoreboard for nibble_add_seq (NIBBLES=4).
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_nibble_add_seq;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_ovf;
  logic [3:0]   fa_a;
  logic [3:0]   fa_b;
  logic         fa_cin;
  logic [3:0]   fa_sum;
  logic         fa_cout;

  int   checks;
  int   errors;
  exp_t q[$];

  nibble_add_seq #(.NIBBLES(NIB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_cin   (op_cin),
    .op_sub   (op_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res_sum  (res_sum),
    .res_cout (res_cout),
    .res_ovf  (res_ovf),
    .fa_a     (fa_a),
    .fa_b     (fa_b),
    .fa_cin   (fa_cin),
    .fa_sum   (fa_sum),
    .fa_cout  (fa_cout)
  );

  // Behavioural stand-in for the external ripple-carry adder.
  assign {fa_cout, fa_sum} = {1'b0, fa_a} + {1'b0, fa_b} + {4'd0, fa_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t         e;
    logic [W-1:0] beff;
    logic [W:0]   t;
    beff   = sub ? ~b : b;
    t      = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (a[W-1] == beff[W-1]) && (e.sum[W-1] != a[W-1]);
    return e;
  endfunction

  // Called at the negedge just after the accepting edge; checks adder pin
  // drive for each nibble and the exact result latency.
  task automatic run_check(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub);
    logic [W-1:0] beff;
    logic         c;
    logic [4:0]   t;
    beff = sub ? ~b : b;
    c    = sub ? 1'b1 : cin;
    for (int i = 0; i < NIB; i++) begin
      chk($sformatf("fa_a[%0d]", i), 32'(fa_a), 32'(a[4*i +: 4]));
      chk($sformatf("fa_b[%0d]", i), 32'(fa_b), 32'(beff[4*i +: 4]));
      chk($sformatf("fa_cin[%0d]", i), 32'(fa_cin), 32'(c));
      chk("in_ready_run", 32'(in_ready), 32'd0);
      chk("out_valid_run", 32'(out_valid), 32'd0);
      t = {1'b0, a[4*i +: 4]} + {1'b0, beff[4*i +: 4]} + {4'd0, c};
      c = t[4];
      @(negedge clk);
    end
    chk("out_valid_latency", 32'(out_valid), 32'd1);
  endtask

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    op_sub   = sub;
    in_valid = 1'b1;
    q.push_back(model(a, b, cin, sub));
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    drive_op(a, b, cin, sub);
    @(negedge clk);
    in_valid = 1'b0;
    run_check(a, b, cin, sub);
  endtask

  task automatic compare_head(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = q.pop_front();
    chk({tag, "_sum"}, 32'(res_sum), 32'(e.sum));
    chk({tag, "_cout"}, 32'(res_cout), 32'(e.cout));
    chk({tag, "_ovf"}, 32'(res_ovf), 32'(e.ovf));
  endtask

  // Consume the result after 'hold' back-pressured cycles, wiggling the
  // operand inputs meanwhile to show they are ignored.
  task automatic recv(input string tag, input int hold);
    logic [W-1:0] held_sum;
    held_sum = res_sum;
    compare_head(tag);
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      op_a     = W'($urandom);
      op_b     = W'($urandom);
      op_sub   = 1'($urandom);
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_sum", 32'(res_sum), 32'(held_sum));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("consumed_out_valid", 32'(out_valid), 32'd0);
    chk("consumed_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_cin    = 1'b0;
    op_sub    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(res_sum), 32'd0);
    chk("rst_cout", 32'(res_cout), 32'd0);
    chk("rst_ovf", 32'(res_ovf), 32'd0);
    chk("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);

    send(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    recv("add", 0);

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    recv("wrap", 0);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    recv("cin_wrap", 0);

    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    recv("ovf_pos", 0);
    send(16'h8000, 16'h8000, 1'b0, 1'b0);
    recv("ovf_neg", 0);

    send(16'h0005, 16'h0007, 1'b1, 1'b1);
    recv("sub_borrow", 0);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    recv("sub_ovf", 0);

    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    recv("backpressure", 5);
    send(16'hABCD, 16'h1357, 1'b1, 1'b0);
    recv("after_bp", 0);

    // Result consumed while new operands are offered: they must wait a cycle.
    send(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    compare_head("simul");
    out_ready = 1'b1;
    drive_op(16'h4321, 16'h1234, 1'b0, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    chk("simul_not_accepted", 32'(in_ready), 32'd1);
    chk("simul_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    run_check(16'h4321, 16'h1234, 1'b0, 1'b1);
    recv("simul_next", 0);

    // Asynchronous reset during the second RUN cycle.
    @(negedge clk);
    op_a     = 16'hFFFF;
    op_b     = 16'hFFFF;
    op_cin   = 1'b1;
    op_sub   = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sum", 32'(res_sum), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    send(16'h0001, 16'h0001, 1'b0, 1'b0);
    recv("post_rst_add", 0);

    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
